// File: rtl/dac_multichannel_ctrl.sv
// Multi-channel DAC setpoint controller: debounced less/more adjust per channel,
// round-robin SPI transfer scheduling over the dactrig/dacdone handshake.
module dac_multichannel_ctrl #(
  parameter int CHANNELS       = 4,
  parameter int DATA_W         = 12,
  parameter int STEP_SHIFT     = 2,
  parameter int REFRESH_CYCLES = 50000000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic              less,
  input  logic              more,
  input  logic [1:0]        sel,
  input  logic [1:0]        step_exp,
  output logic [DATA_W-1:0] data,
  output logic [3:0]        address,
  output logic [3:0]        command,
  output logic              dactrig,
  input  logic              dacdone,
  output logic              busy,
  output logic              err,
  output logic [7:0]        LED
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = (REFRESH_CYCLES > 0) ? RW'(REFRESH_CYCLES - 1) : '0;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [DATA_W-1:0] SP_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   setpoint [CHANNELS];
  logic [CHANNELS-1:0] dirty, dirty_nxt;
  logic [1:0]          rr, cur, pick, idx;
  logic                found;
  logic [DATA_W-1:0]   data_q;
  logic [RW-1:0]       ref_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic [DATA_W-1:0]   sp_sel, sp_new;
  logic [31:0]         step, sp_ext;
  logic                adj_valid, adj_change, timeout, ref_fire;

  assign command = 4'b0011;

  // Saturating adjust of the selected channel; a saturated pulse is not a change.
  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    sp_sel     = '0;
    sp_new     = '0;
    adj_change = 1'b0;
    adj_valid  = (int'(sel) < CHANNELS) && (more ^ less);
    if (int'(sel) < CHANNELS) sp_sel = setpoint[sel];
    step   = 32'd1 << (32'(step_exp) * 32'(STEP_SHIFT));
    sp_ext = 32'(sp_sel);
    if (more) sp_new = (sp_ext + step > 32'(SP_MAX)) ? SP_MAX : DATA_W'(sp_ext + step);
    else      sp_new = (step > sp_ext) ? '0 : DATA_W'(sp_ext - step);
    adj_change = adj_valid && (sp_new != sp_sel);
    LED        = sp_sel[DATA_W-1 -: 8];
  end

  // First dirty channel at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = 2'((int'(rr) + i) % CHANNELS);
      if (!found && dirty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign timeout  = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) && !dacdone && (tmo_cnt == TMO_LAST);
  assign ref_fire = (REFRESH_CYCLES != 0) && (state == S_IDLE) && (dirty == '0) &&
                    !(less || more) && (ref_cnt == REF_LAST);

  // Later assignments win: an adjust in the ISSUE cycle re-marks the channel being sent.
  always_comb begin
    dirty_nxt = dirty;
    if (state == S_ISSUE) dirty_nxt[cur] = 1'b0;
    if (timeout)          dirty_nxt[cur] = 1'b1;
    if (ref_fire)         dirty_nxt      = '1;
    if (adj_change)       dirty_nxt[sel] = 1'b1;
  end

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (dacdone || timeout) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // During ISSUE the live setpoint is presented; data_q holds it through WAIT.
  always_comb begin
    dactrig = (state == S_ISSUE);
    busy    = (state != S_IDLE);
    data    = (state == S_ISSUE) ? setpoint[cur] : data_q;
    address = 4'(cur);
  end

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      // NOTE: the setpoints are a small flop array, not RAM, so they reset with everything else.
      for (int c = 0; c < CHANNELS; c++) setpoint[c] <= '0;
      dirty   <= '1;
      rr      <= '0;
      cur     <= '0;
      data_q  <= '0;
      err     <= 1'b0;
      ref_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (adj_change) setpoint[sel] <= sp_new;
      dirty <= dirty_nxt;
      if (state == S_IDLE && found) cur <= pick;
      if (state == S_ISSUE) begin
        data_q <= setpoint[cur];
        rr     <= 2'((int'(cur) + 1) % CHANNELS);
      end
      if (timeout) err <= 1'b1;
      tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (less || more || state != S_IDLE || ref_fire) ref_cnt <= '0;
      else if (REFRESH_CYCLES != 0 && dirty == '0)    ref_cnt <= ref_cnt + 1'b1;
    end
  end

endmodule

// File: doc/dac_multichannel_ctrl.md
Name: dac_multichannel_ctrl

Overview:
- Parametrised successor to the single-channel DAC controller.
- Holds CHANNELS independent DATA_W-bit setpoints, adjusted by debounced less/more pulses with a selectable step.
- Schedules SPI transfers to the DacSpi engine over the dactrig/dacdone handshake: round-robin over dirty channels, optional periodic refresh, transfer timeout detection.
- Sits between the Debouncer instances and DacSpi in Top.

Parameters:
- CHANNELS, 4, number of DAC channels (1..4); channel c drives address c.
- DATA_W, 12, setpoint width in bits; equals DacSpi data width.
- STEP_SHIFT, 2, step = 1 << (step_exp*STEP_SHIFT).
- REFRESH_CYCLES, 50000000, idle cycles before all channels are re-marked dirty; 0 disables refresh.
- TIMEOUT_CYCLES, 4096, max cycles waiting for dacdone; 0 disables timeout.

Ports:
- CLK50MHZ  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- less  in  1  one-cycle decrement pulse
- more  in  1  one-cycle increment pulse
- sel  in  2  channel selected for adjustment; values >= CHANNELS are ignored (no change)
- step_exp  in  2  step exponent
- data  out  DATA_W  setpoint of channel in transfer
- address  out  4  DAC address (channel index)
- command  out  4  DAC command; always 4'b0011 (write and update)
- dactrig  out  1  one-cycle transfer request to DacSpi
- dacdone  in  1  one-cycle completion pulse from DacSpi
- busy  out  1  transfer in flight
- err  out  1  sticky timeout flag
- LED  out  8  setpoint[DATA_W-1 -: 8] of the selected channel

Behaviour:
- One clock, CLK50MHZ. RST is asynchronous, active-high. Assertion takes effect immediately, including mid-transfer.
- Reset values:
  - all setpoints 0; dirty mask all 1 (initial sync after reset); rr pointer 0; FSM IDLE
  - data 0, address 0, command 4'b0011, dactrig 0, busy 0, err 0, refresh and timeout counters 0
- Adjust, evaluated every cycle:
  - more & !less: setpoint[sel] += step, saturating at 2^DATA_W-1.
  - less & !more: setpoint[sel] -= step, saturating at 0.
  - both asserted or sel invalid: no change.
  - Any change sets dirty[sel]. A saturated no-op leaves dirty unchanged.
- Refresh counter: increments in IDLE when no channel is dirty. Cleared by any adjust pulse or any transfer. On reaching REFRESH_CYCLES-1 it sets every dirty bit and clears.
- FSM:
  - IDLE: if any dirty bit is set, pick the first dirty channel searching from rr, wrapping modulo CHANNELS, and go to ISSUE.
  - ISSUE (1 cycle):
    - latch data=setpoint[c], address=c; dactrig=1; busy=1; clear dirty[c]; rr=(c+1) mod CHANNELS.
    - If an adjust to the same channel occurs this cycle, dirty[c] ends set and data latches the pre-adjust value.
    - Go to WAIT.
  - WAIT:
    - dactrig=0; data/address/command held stable.
    - On dacdone: busy=0, go to IDLE.
    - A dacdone seen outside WAIT is ignored.
    - If the timeout counter reaches TIMEOUT_CYCLES-1: err=1, set dirty[c] again, busy=0, go to IDLE.
- Latency:
  - Adjust pulse in cycle N gives dirty at N+1, ISSUE at N+2 (FSM idle).
  - Transfer back-to-back: IDLE is 1 cycle between dacdone and the next ISSUE.
- Adjusts during WAIT are accepted. A modified channel is re-sent on a later pass and is never lost.
- err clears only on RST.
- CHANNELS=1: rr is always 0, address always 0.

Test Plan:
- Reset, DacSpi model returns dacdone 20 cycles after dactrig -> four transfers in order: addresses 0,1,2,3, data 0, command 4'b0011; then idle with busy=0.
- sel=1, step_exp=0, three more pulses -> setpoint[1]=3; one transfer, address 1, data 12'h003; LED=8'h00.
- sel=2, step_exp=3, STEP_SHIFT=2 (step=64), 70 more pulses -> setpoint saturates at 12'hFFF; a further more pulse causes no transfer; less pulse -> 12'hFBF.
- Adjust channel 0 during WAIT of its own transfer -> after dacdone, a second transfer for address 0 carrying the new value.
- less and more in the same cycle -> no setpoint change, no dactrig.
- Model withholds dacdone -> err=1 after TIMEOUT_CYCLES, channel retried. RST asserted mid-WAIT -> dactrig/busy 0 immediately, full 4-channel resync afterwards.
